// File: rtl/fifo_drain_pkg.sv
// Shared types and defaults for the FIFO read-side drain controller.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } drain_state_e;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FRAME_LEN  = 8;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry in-order buffer between the FIFO read port and the output stream.
module drain_skid_buf #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;

  // slot0 is always the oldest word; the caller never pushes when full or pops when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      occ   <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) slot0 <= din;
          else             slot1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/fifo_drain.sv
// Pops a synchronous FIFO and re-presents its words as a framed valid/ready stream.
// Stream handshake: a word transfers on a rising edge where m_valid && m_ready; m_valid never falls without a transfer.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAME_LEN  = DEFAULT_FRAME_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         fifo_empty,
  input  logic [DATA_WIDTH-1:0]        fifo_dout,
  output logic                         fifo_rd_en,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_last,
  output logic [$clog2(FRAME_LEN)-1:0] word_idx,
  output logic                         frame_done,
  output logic                         busy,
  output drain_state_e                 state
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  logic [1:0] occ;
  logic       inflight;
  logic       pop;
  logic [2:0] committed;

  drain_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (fifo_dout),
    .occ   (occ),
    .head  (m_data)
  );

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (word_idx == LAST_IDX);
  assign busy    = (state != IDLE);

  // Words already owed a buffer slot after this cycle's pop; a read is safe only below 2.
  assign committed  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (committed < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      inflight   <= 1'b0;
      word_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      inflight   <= fifo_rd_en;
      frame_done <= pop && m_last;
      if (pop) begin
        if (word_idx == LAST_IDX) word_idx <= '0;
        else                      word_idx <= word_idx + IW'(1);
      end
      case (state)
        IDLE:  if (enable) state <= RUN;
        RUN:   if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable)                                 state <= RUN;
          else if ((occ == 2'd0) && !inflight)        state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
